// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: definitions shared by the alu_arb arbiter and its users.
//   ALU_BITS_DEFAULT       default operand/result width
//   ALU_CTRL_BITS_DEFAULT  default ALU control code width
//   state_t                response register state (IDLE empty, HOLD full)
//   ALUCTRL_*              control codes understood by the shared ALU
package alu_arb_pkg;

  localparam int ALU_BITS_DEFAULT      = 32;
  localparam int ALU_CTRL_BITS_DEFAULT = 5;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [4:0] ALUCTRL_ADD  = 5'd0;
  localparam logic [4:0] ALUCTRL_SUB  = 5'd1;
  localparam logic [4:0] ALUCTRL_AND  = 5'd2;
  localparam logic [4:0] ALUCTRL_OR   = 5'd3;
  localparam logic [4:0] ALUCTRL_XOR  = 5'd4;
  localparam logic [4:0] ALUCTRL_SLL  = 5'd5;
  localparam logic [4:0] ALUCTRL_SRL  = 5'd6;
  localparam logic [4:0] ALUCTRL_SRA  = 5'd7;
  localparam logic [4:0] ALUCTRL_SLT  = 5'd8;
  localparam logic [4:0] ALUCTRL_SLTU = 5'd9;
  localparam logic [4:0] ALUCTRL_BEQ  = 5'd10;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant selection (purely combinational).
// Ports:
//   valid[1:0]  requests
//   pointer     index of the requester granted most recently
//   enable      grants may be issued this cycle
//   grant[1:0]  one-hot grant, 2'b00 when disabled or nothing valid
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       pointer,
  input  logic       enable,
  output logic [1:0] grant
);

  // A lone requester always wins; on contention the one not served last wins.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = pointer ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/alu_arb.sv
// alu_arb: shares one combinational ALU between two requesters and registers
// the ALU result into a single-entry response buffer.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            per-requester request handshake
//   req_rdata1/rdata2/imm/alu_src/alu_ctrl  per-requester operation fields
//   alu_rdata1/rdata2/imm/src/ctrl operands to the shared ALU (zero when idle)
//   alu_result, alu_is_zero        combinational ALU outputs
//   rsp_valid/rsp_ready            response handshake
//   rsp_id, rsp_result, rsp_is_zero registered response
// Optional (macro ALU_ARB_PERF_EN): perf_grant0, perf_grant1, perf_stall
// 32-bit wrapping event counters.
module alu_arb
  import alu_arb_pkg::*;
#(
  parameter int ALU_BITS      = ALU_BITS_DEFAULT,
  parameter int ALU_CTRL_BITS = ALU_CTRL_BITS_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [2*ALU_BITS-1:0]      req_rdata1,
  input  logic [2*ALU_BITS-1:0]      req_rdata2,
  input  logic [2*ALU_BITS-1:0]      req_imm,
  input  logic [1:0]                 req_alu_src,
  input  logic [2*ALU_CTRL_BITS-1:0] req_alu_ctrl,
  output logic [ALU_BITS-1:0]        alu_rdata1,
  output logic [ALU_BITS-1:0]        alu_rdata2,
  output logic [ALU_BITS-1:0]        alu_imm,
  output logic                       alu_src,
  output logic [ALU_CTRL_BITS-1:0]   alu_ctrl,
  input  logic [ALU_BITS-1:0]        alu_result,
  input  logic                       alu_is_zero,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_id,
  output logic [ALU_BITS-1:0]        rsp_result,
  output logic                       rsp_is_zero
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]                perf_grant0,
  output logic [31:0]                perf_grant1,
  output logic [31:0]                perf_stall
`endif
);

  state_t              state_q, state_d;
  logic                last_q;
  logic                can_grant;
  logic [1:0]          grant;
  logic                accept;
  logic                sel;
  logic                rsp_id_q;
  logic [ALU_BITS-1:0] rsp_result_q;
  logic                rsp_is_zero_q;

  // The buffer can take a new op when empty or when it drains this cycle.
  // Reset blocks grants so nothing is accepted during any reset cycle.
  assign can_grant = !rst && ((state_q == IDLE) || rsp_ready);

  rr_arb2 u_rr (
    .valid   (req_valid),
    .pointer (last_q),
    .enable  (can_grant),
    .grant   (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign sel       = grant[1];

  // Steer the granted requester onto the ALU; all zero when nobody is granted.
  always_comb begin
    alu_rdata1 = '0;
    alu_rdata2 = '0;
    alu_imm    = '0;
    alu_src    = 1'b0;
    alu_ctrl   = '0;
    if (accept) begin
      if (sel) begin
        alu_rdata1 = req_rdata1[2*ALU_BITS-1:ALU_BITS];
        alu_rdata2 = req_rdata2[2*ALU_BITS-1:ALU_BITS];
        alu_imm    = req_imm[2*ALU_BITS-1:ALU_BITS];
        alu_src    = req_alu_src[1];
        alu_ctrl   = req_alu_ctrl[2*ALU_CTRL_BITS-1:ALU_CTRL_BITS];
      end else begin
        alu_rdata1 = req_rdata1[ALU_BITS-1:0];
        alu_rdata2 = req_rdata2[ALU_BITS-1:0];
        alu_imm    = req_imm[ALU_BITS-1:0];
        alu_src    = req_alu_src[0];
        alu_ctrl   = req_alu_ctrl[ALU_CTRL_BITS-1:0];
      end
    end
  end

  // Next state: an accept always leaves the buffer full; a drain without a
  // new accept empties it; a stalled response stays put.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = HOLD;
      HOLD:    if (rsp_ready) state_d = accept ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, round-robin pointer and response register. The pointer starts at
  // requester 1 so requester 0 wins the first contested grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      rsp_id_q      <= 1'b0;
      rsp_result_q  <= '0;
      rsp_is_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_q        <= sel;
        rsp_id_q      <= sel;
        rsp_result_q  <= alu_result;
        rsp_is_zero_q <= alu_is_zero;
      end
    end
  end

  assign rsp_valid   = (state_q == HOLD);
  assign rsp_id      = rsp_id_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_is_zero = rsp_is_zero_q;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] grant0_q, grant1_q, stall_q;

  // Event counters; a stall is a cycle with a pending request and no grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant0_q <= '0;
      grant1_q <= '0;
      stall_q  <= '0;
    end else begin
      if (grant[0]) grant0_q <= grant0_q + 32'd1;
      if (grant[1]) grant1_q <= grant1_q + 32'd1;
      if ((|req_valid) && !accept) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_grant0 = grant0_q;
  assign perf_grant1 = grant1_q;
  assign perf_stall  = stall_q;
`endif

endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: self-checking bench for alu_arb. A behavioural ALU drives the
// shared-ALU inputs; a reference model tracks the expected response buffer,
// grant history and (with ALU_ARB_PERF_EN) event counters.
module tb_alu_arb;
  import alu_arb_pkg::*;

  localparam int W = 32;
  localparam int C = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_rdata1, req_rdata2, req_imm;
  logic [1:0]     req_alu_src;
  logic [2*C-1:0] req_alu_ctrl;
  logic [W-1:0]   alu_rdata1, alu_rdata2, alu_imm;
  logic           alu_src;
  logic [C-1:0]   alu_ctrl;
  logic [W-1:0]   alu_result;
  logic           alu_is_zero;
  logic           rsp_valid, rsp_ready, rsp_id, rsp_is_zero;
  logic [W-1:0]   rsp_result;
`ifdef ALU_ARB_PERF_EN
  logic [31:0]    perf_grant0, perf_grant1, perf_stall;
  logic [31:0]    pg0 = '0, pg1 = '0, pst = '0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state: expected response buffer and the order of past grants.
  bit           mValid = 1'b0;
  bit           mId = 1'b0;
  logic [W-1:0] mRes = '0;
  bit           mZero = 1'b0;
  int           grantHist[$];

  always #5 clk = ~clk;

  alu_arb dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rdata1   (req_rdata1),
    .req_rdata2   (req_rdata2),
    .req_imm      (req_imm),
    .req_alu_src  (req_alu_src),
    .req_alu_ctrl (req_alu_ctrl),
    .alu_rdata1   (alu_rdata1),
    .alu_rdata2   (alu_rdata2),
    .alu_imm      (alu_imm),
    .alu_src      (alu_src),
    .alu_ctrl     (alu_ctrl),
    .alu_result   (alu_result),
    .alu_is_zero  (alu_is_zero),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_is_zero  (rsp_is_zero)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_grant0  (perf_grant0),
    .perf_grant1  (perf_grant1),
    .perf_stall   (perf_stall)
`endif
  );

  function automatic logic [W-1:0] aluRef(input logic [C-1:0] ctrl,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W-1:0] r;
    case (ctrl)
      ALUCTRL_ADD:  r = a + b;
      ALUCTRL_SUB:  r = a - b;
      ALUCTRL_AND:  r = a & b;
      ALUCTRL_OR:   r = a | b;
      ALUCTRL_XOR:  r = a ^ b;
      ALUCTRL_SLL:  r = a << b[4:0];
      ALUCTRL_SRL:  r = a >> b[4:0];
      ALUCTRL_SRA:  r = $signed(a) >>> b[4:0];
      ALUCTRL_SLT:  r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALUCTRL_SLTU: r = {{(W-1){1'b0}}, (a < b)};
      ALUCTRL_BEQ:  r = a - b;
      default:      r = '0;
    endcase
    return r;
  endfunction

  // The shared ALU seen by the DUT.
  always_comb begin
    alu_result  = aluRef(alu_ctrl, alu_rdata1, alu_src ? alu_imm : alu_rdata2);
    alu_is_zero = (alu_result == '0);
  end

  function automatic logic [W-1:0] wordOf(input logic [2*W-1:0] bus, input int n);
    return (n == 1) ? bus[2*W-1:W] : bus[W-1:0];
  endfunction

  function automatic logic [C-1:0] ctrlOf(input int n);
    return (n == 1) ? req_alu_ctrl[2*C-1:C] : req_alu_ctrl[C-1:0];
  endfunction

  // Expected grant from the arbitration rules: no grant in reset or while a
  // stalled response occupies the buffer; contested grants alternate with
  // the most recent winner (requester 0 first after reset).
  function automatic logic [1:0] expReady();
    int winner;
    if (rst) return 2'b00;
    if (mValid && !rsp_ready) return 2'b00;
    if (req_valid == 2'b00) return 2'b00;
    if (req_valid == 2'b01) return 2'b01;
    if (req_valid == 2'b10) return 2'b10;
    winner = (grantHist.size() == 0) ? 0 : 1 - grantHist[$];
    return (winner == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] v, input logic rr);
    rst       = r;
    req_valid = v;
    rsp_ready = rr;
    #1;
  endtask

  task automatic setReq(input int n, input logic [C-1:0] ctrl, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] imm, input logic src);
    if (n == 1) begin
      req_rdata1[2*W-1:W]  = a;
      req_rdata2[2*W-1:W]  = b;
      req_imm[2*W-1:W]     = imm;
      req_alu_src[1]       = src;
      req_alu_ctrl[2*C-1:C] = ctrl;
    end else begin
      req_rdata1[W-1:0]    = a;
      req_rdata2[W-1:0]    = b;
      req_imm[W-1:0]       = imm;
      req_alu_src[0]       = src;
      req_alu_ctrl[C-1:0]  = ctrl;
    end
  endtask

  // One clock: compare everything against the model at the falling edge,
  // then advance the model with the inputs the DUT sampled at the rising edge.
  task automatic runCycle();
    logic [1:0]   er;
    int           w;
    logic [W-1:0] opb;
    @(negedge clk);
    er = expReady();
    checkOutput("req_ready", {62'd0, req_ready}, {62'd0, er});
    checkOutput("rsp_valid", {63'd0, rsp_valid}, {63'd0, mValid});
    if (mValid) begin
      checkOutput("rsp_id", {63'd0, rsp_id}, {63'd0, mId});
      checkOutput("rsp_result", {32'd0, rsp_result}, {32'd0, mRes});
      checkOutput("rsp_is_zero", {63'd0, rsp_is_zero}, {63'd0, mZero});
    end
    if (er != 2'b00) begin
      w = er[1] ? 1 : 0;
      checkOutput("alu_rdata1", {32'd0, alu_rdata1}, {32'd0, wordOf(req_rdata1, w)});
      checkOutput("alu_rdata2", {32'd0, alu_rdata2}, {32'd0, wordOf(req_rdata2, w)});
      checkOutput("alu_imm", {32'd0, alu_imm}, {32'd0, wordOf(req_imm, w)});
      checkOutput("alu_src", {63'd0, alu_src}, {63'd0, req_alu_src[w]});
      checkOutput("alu_ctrl", {59'd0, alu_ctrl}, {59'd0, ctrlOf(w)});
    end else begin
      checkOutput("alu_idle", {31'd0, alu_rdata1 | alu_rdata2 | alu_imm, alu_src | (|alu_ctrl)},
                  64'd0);
    end
    @(posedge clk);
`ifdef ALU_ARB_PERF_EN
    if (rst) begin
      pg0 = '0; pg1 = '0; pst = '0;
    end else begin
      if (er == 2'b01) pg0 = pg0 + 32'd1;
      if (er == 2'b10) pg1 = pg1 + 32'd1;
      if ((req_valid != 2'b00) && (er == 2'b00)) pst = pst + 32'd1;
    end
`endif
    if (rst) begin
      mValid = 1'b0; mId = 1'b0; mRes = '0; mZero = 1'b0;
      grantHist.delete();
    end else if (er != 2'b00) begin
      w      = er[1] ? 1 : 0;
      opb    = req_alu_src[w] ? wordOf(req_imm, w) : wordOf(req_rdata2, w);
      mValid = 1'b1;
      mId    = (w == 1);
      mRes   = aluRef(ctrlOf(w), wordOf(req_rdata1, w), opb);
      mZero  = (mRes == '0);
      grantHist.push_back(w);
      if (grantHist.size() > 8) void'(grantHist.pop_front());
    end else if (mValid && rsp_ready) begin
      mValid = 1'b0;
    end
    #1;
  endtask

  initial begin
    logic [1:0]   seq[4];
    logic [W-1:0] held;
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
    req_rdata1 = '0; req_rdata2 = '0; req_imm = '0;
    req_alu_src = '0; req_alu_ctrl = '0;

    // Reset with both requesting: no grants, empty buffer.
    applyStimulus(1'b1, 2'b11, 1'b1);
    runCycle();
    runCycle();
    checkOutput("reset_ready", {62'd0, req_ready}, 64'd0);
    checkOutput("reset_rsp", {31'd0, rsp_result, rsp_valid, rsp_id, rsp_is_zero}, 64'd0);

    // Single ADD from requester 0, one cycle latency.
    setReq(0, ALUCTRL_ADD, 32'd5, 32'd7, 32'd0, 1'b0);
    applyStimulus(1'b0, 2'b01, 1'b1);
    checkOutput("add_ready", {62'd0, req_ready}, 64'd1);
    runCycle();
    checkOutput("add_rsp", {30'd0, rsp_result, rsp_valid, rsp_id}, {30'd0, 32'd12, 2'b10});

    // Fresh reset, then both contending: grants alternate 0,1,0,1 with no bubbles.
    applyStimulus(1'b1, 2'b11, 1'b1);
    runCycle();
    setReq(0, ALUCTRL_ADD, 32'd100, 32'd1, 32'd0, 1'b0);
    setReq(1, ALUCTRL_XOR, 32'hF0F0, 32'h0FF0, 32'd0, 1'b0);
    applyStimulus(1'b0, 2'b11, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("rr_grant", {62'd0, req_ready}, {62'd0, seq[i]});
      runCycle();
      checkOutput("rr_rsp_id", {62'd0, rsp_valid, rsp_id}, {62'd0, 1'b1, seq[i][1]});
    end

    // SUB with immediate from requester 1 alone.
    setReq(1, ALUCTRL_SUB, 32'd3, 32'd55, 32'd10, 1'b1);
    applyStimulus(1'b0, 2'b10, 1'b1);
    runCycle();
    checkOutput("sub_imm", {31'd0, rsp_result, rsp_id}, {31'd0, 32'hFFFF_FFF9, 1'b1});

    // BEQ 9,9 then a 3-cycle stall: response frozen and no grants.
    setReq(0, ALUCTRL_BEQ, 32'd9, 32'd9, 32'd0, 1'b0);
    applyStimulus(1'b0, 2'b01, 1'b1);
    runCycle();
    checkOutput("beq_zero", {63'd0, rsp_is_zero}, 64'd1);
    held = rsp_result;
    for (int i = 0; i < 3; i++) begin
      setReq(0, ALUCTRL_ADD, $urandom, $urandom, $urandom, 1'b0);
      setReq(1, ALUCTRL_OR, $urandom, $urandom, $urandom, 1'b1);
      applyStimulus(1'b0, 2'b11, 1'b0);
      checkOutput("stall_ready", {62'd0, req_ready}, 64'd0);
      runCycle();
      checkOutput("stall_hold", {31'd0, rsp_result, rsp_is_zero}, {31'd0, held, 1'b1});
    end
    applyStimulus(1'b0, 2'b11, 1'b1);
    checkOutput("resume_ready", {62'd0, req_ready}, 64'd2);
    runCycle();

    // Drain with no new request: buffer empties.
    applyStimulus(1'b0, 2'b00, 1'b1);
    runCycle();
    checkOutput("drain_valid", {63'd0, rsp_valid}, 64'd0);

    // Reset while holding a stalled response discards it.
    setReq(1, ALUCTRL_AND, 32'hFF, 32'h0F, 32'd0, 1'b0);
    applyStimulus(1'b0, 2'b10, 1'b0);
    runCycle();
    applyStimulus(1'b1, 2'b11, 1'b0);
    checkOutput("rst_hold_ready", {62'd0, req_ready}, 64'd0);
    runCycle();
    applyStimulus(1'b0, 2'b11, 1'b1);
    checkOutput("rst_hold_valid", {63'd0, rsp_valid}, 64'd0);
    checkOutput("rst_first_grant", {62'd0, req_ready}, 64'd1);
    runCycle();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < 2; n++)
        setReq(n, C'($urandom_range(0, 10)), $urandom, $urandom,
               ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, 1'($urandom));
      if ($urandom_range(0, 7) == 0) req_rdata2[W-1:0] = req_rdata1[W-1:0];
      applyStimulus(($urandom_range(0, 40) == 0), 2'($urandom), 1'($urandom));
      runCycle();
    end

`ifdef ALU_ARB_PERF_EN
    applyStimulus(1'b0, 2'b00, 1'b1);
    @(negedge clk);
    checkOutput("perf_grant0", {32'd0, perf_grant0}, {32'd0, pg0});
    checkOutput("perf_grant1", {32'd0, perf_grant1}, {32'd0, pg1});
    checkOutput("perf_stall", {32'd0, perf_stall}, {32'd0, pst});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
